// File: rtl/raster_stamp_queue.sv
// Buffer between the raster stamp generator and the per-core raster CSR port.
// Stamps are packed into CSR form (bcoords + pos_mask word) when they are pushed.
module raster_stamp_queue #(
  parameter int DEPTH      = 8,
  parameter int DIM_BITS   = 12,
  parameter int PID_BITS   = 16,
  parameter int QUAD_SIZE  = 4,
  parameter int DROP_EMPTY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DIM_BITS-2:0]         in_pos_x,
  input  logic [DIM_BITS-2:0]         in_pos_y,
  input  logic [QUAD_SIZE-1:0]        in_mask,
  input  logic [3*QUAD_SIZE*32-1:0]   in_bcoords,
  input  logic [PID_BITS-1:0]         in_pid,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [3*QUAD_SIZE*32-1:0]   out_bcoords,
  output logic [31:0]                 out_pos_mask,
  output logic [PID_BITS-1:0]         out_pid,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty,
  output logic                        full,
  output logic [15:0]                 drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = DIM_BITS - 1;
  localparam int BW = 3 * QUAD_SIZE * 32;

  if (2 * (DIM_BITS - 1) + QUAD_SIZE > 32) begin : g_fmt_check
    $fatal(1, "raster_stamp_queue: pos/mask fields exceed 32 bits");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $fatal(1, "raster_stamp_queue: DEPTH must be a power of two >= 2");
  end

  logic [31:0]         pm_mem  [DEPTH];
  logic [BW-1:0]       bc_mem  [DEPTH];
  logic [PID_BITS-1:0] pid_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [15:0]   drop_cnt;

  logic [31:0] pos_mask_in;
  logic        stamp_empty;
  logic        accept;
  logic        push;
  logic        drop;
  logic        pop;

  always_comb begin
    pos_mask_in                        = '0;
    pos_mask_in[QUAD_SIZE-1:0]         = in_mask;
    pos_mask_in[QUAD_SIZE +: PW]       = in_pos_x;
    pos_mask_in[QUAD_SIZE + PW +: PW]  = in_pos_y;
  end

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign count       = count_q;
  assign drop_count  = drop_cnt;

  assign stamp_empty = (DROP_EMPTY != 0) && (in_mask == '0);
  assign accept      = in_valid && in_ready;
  assign push        = accept && !stamp_empty;
  assign drop        = accept && stamp_empty;
  assign pop         = out_valid && out_ready;

  assign out_pos_mask = pm_mem[rd_ptr];
  assign out_bcoords  = bc_mem[rd_ptr];
  assign out_pid      = pid_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pm_mem[wr_ptr]  <= pos_mask_in;
      bc_mem[wr_ptr]  <= in_bcoords;
      pid_mem[wr_ptr] <= in_pid;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      drop_cnt <= '0;
    end else begin
      // a dropped stamp still counts even when flush discards the queue
      if (drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + 16'd1;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)
          count_q <= count_q + CW'(1);
        else if (pop && !push)
          count_q <= count_q - CW'(1);
      end
    end
  end

endmodule
